// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: the queued entry layout and the bubble instruction.
package fetch_pkg;

  localparam int FQ_ADDR_W  = 64;
  localparam int FQ_INSTR_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Entries are stored at the maximum supported widths; narrower builds zero-extend on write.
  typedef struct packed {
    logic [FQ_INSTR_W-1:0] instr;
    logic [FQ_ADDR_W-1:0]  pc;
    logic                  pred_taken;
    logic [1:0]            btb_way;
    logic [FQ_ADDR_W-1:0]  pc_target_pred;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fill/head bundle between the instruction cache, the fetch queue and the decode register.
interface fetch_queue_if #(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
);
  logic                     i_stall_dec;
  logic                     i_fill_valid;
  logic [INSTR_WIDTH-1:0]   i_fill_instr;
  logic [ADDR_WIDTH-1:0]    i_fill_pc;
  logic                     i_fill_pred_taken;
  logic [1:0]               i_fill_btb_way;
  logic [ADDR_WIDTH-1:0]    i_fill_pc_target_pred;
  logic                     o_fill_ready;
  logic                     o_valid;
  logic [INSTR_WIDTH-1:0]   o_instr;
  logic [ADDR_WIDTH-1:0]    o_pc;
  logic [ADDR_WIDTH-1:0]    o_pc_plus4;
  logic                     o_branch_pred_taken;
  logic [1:0]               o_btb_way;
  logic [ADDR_WIDTH-1:0]    o_pc_target_pred;
  logic [$clog2(DEPTH):0]   o_count;

  modport master (
    output i_stall_dec, i_fill_valid, i_fill_instr, i_fill_pc, i_fill_pred_taken,
           i_fill_btb_way, i_fill_pc_target_pred,
    input  o_fill_ready, o_valid, o_instr, o_pc, o_pc_plus4, o_branch_pred_taken,
           o_btb_way, o_pc_target_pred, o_count
  );

  modport slave (
    input  i_stall_dec, i_fill_valid, i_fill_instr, i_fill_pc, i_fill_pred_taken,
           i_fill_btb_way, i_fill_pc_target_pred,
    output o_fill_ready, o_valid, o_instr, o_pc, o_pc_plus4, o_branch_pred_taken,
           o_btb_way, o_pc_target_pred, o_count
  );
endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one write port, one asynchronous read port, no reset.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_addr,
  input  fetch_entry_t       wr_data,
  input  logic [PTR_W-1:0]   rd_addr,
  output fetch_entry_t       rd_data
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Show-ahead instruction queue feeding the decode register with instructions and prediction metadata.
// Optional same-cycle fill-to-head bypass on an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic          i_clk,
  input  logic          i_arst,
  input  logic          i_flush,
  fetch_queue_if.slave  fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  fetch_entry_t fill_entry;
  fetch_entry_t mem_head;
  fetch_entry_t head;

  logic empty;
  logic full;
  logic byp;
  logic head_valid;
  logic enq;
  logic mem_deq;

  always_comb begin
    fill_entry                = '0;
    fill_entry.instr          = FQ_INSTR_W'(fq.i_fill_instr);
    fill_entry.pc             = FQ_ADDR_W'(fq.i_fill_pc);
    fill_entry.pred_taken     = fq.i_fill_pred_taken;
    fill_entry.btb_way        = fq.i_fill_btb_way;
    fill_entry.pc_target_pred = FQ_ADDR_W'(fq.i_fill_pc_target_pred);
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty & fq.i_fill_valid & ~i_flush;
`else
  assign byp = 1'b0;
`endif

  assign head_valid = ~empty | byp;

  // A bypassed fill that decode takes immediately never occupies a slot.
  assign enq     = fq.i_fill_valid & ~full & ~(byp & ~fq.i_stall_dec);
  assign mem_deq = ~empty & ~fq.i_stall_dec;

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .i_clk   (i_clk),
    .wr_en   (enq & ~i_flush),
    .wr_addr (wr_ptr),
    .wr_data (fill_entry),
    .rd_addr (rd_ptr),
    .rd_data (mem_head)
  );

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)     wr_ptr <= wr_ptr + PTR_W'(1);
      if (mem_deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(mem_deq);
    end
  end

  // Empty queue presents a NOP bubble with all metadata cleared.
  always_comb begin
    head       = '0;
    head.instr = FQ_INSTR_W'(NOP_INSTR);
    if (byp)         head = fill_entry;
    else if (!empty) head = mem_head;
  end

  assign fq.o_fill_ready        = ~full;
  assign fq.o_valid             = head_valid;
  assign fq.o_instr             = head.instr[INSTR_WIDTH-1:0];
  assign fq.o_pc                = head.pc[ADDR_WIDTH-1:0];
  assign fq.o_pc_plus4          = head_valid ? (head.pc[ADDR_WIDTH-1:0] + ADDR_WIDTH'(4))
                                             : '0;
  assign fq.o_branch_pred_taken = head.pred_taken;
  assign fq.o_btb_way           = head.btb_way;
  assign fq.o_pc_target_pred    = head.pc_target_pred[ADDR_WIDTH-1:0];
  assign fq.o_count             = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, show-ahead, stall, full/wrap, flush, PC wrap, reset mid-run.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int IW    = 32;

  logic clk = 1'b0;
  logic arst;
  logic flush;

  int errors = 0;
  int checks = 0;

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .i_clk  (clk),
    .i_arst (arst),
    .i_flush(flush),
    .fq     (fq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fill(input logic [63:0] pc, input logic [31:0] instr,
                          input logic taken, input logic [1:0] way, input logic [63:0] tgt);
    fq.i_fill_valid          = 1'b1;
    fq.i_fill_pc             = pc;
    fq.i_fill_instr          = instr;
    fq.i_fill_pred_taken     = taken;
    fq.i_fill_btb_way        = way;
    fq.i_fill_pc_target_pred = tgt;
  endtask

  task automatic no_fill();
    fq.i_fill_valid          = 1'b0;
    fq.i_fill_pc             = '0;
    fq.i_fill_instr          = '0;
    fq.i_fill_pred_taken     = 1'b0;
    fq.i_fill_btb_way        = '0;
    fq.i_fill_pc_target_pred = '0;
  endtask

  initial begin
    arst           = 1'b1;
    flush          = 1'b0;
    fq.i_stall_dec = 1'b0;
    no_fill();
    repeat (2) cyc();
    arst = 1'b0;
    #1;

    // Reset state
    chk("rst_valid", 64'(fq.o_valid), 64'd0);
    chk("rst_instr", 64'(fq.o_instr), 64'h13);
    chk("rst_count", 64'(fq.o_count), 64'd0);
    chk("rst_ready", 64'(fq.o_fill_ready), 64'd1);
    chk("rst_pc", fq.o_pc, 64'd0);
    chk("rst_pc4", fq.o_pc_plus4, 64'd0);
    chk("rst_way", 64'(fq.o_btb_way), 64'd0);
    chk("rst_taken", 64'(fq.o_branch_pred_taken), 64'd0);

`ifndef FETCH_QUEUE_BYPASS_EN
    // Single fill becomes visible one cycle later, then drains
    set_fill(64'h1000, 32'h00A0_0093, 1'b0, 2'd0, 64'd0);
    #1;
    chk("one_fill_cycle_valid", 64'(fq.o_valid), 64'd0);
    cyc();
    no_fill();
    #1;
    chk("one_valid", 64'(fq.o_valid), 64'd1);
    chk("one_pc", fq.o_pc, 64'h1000);
    chk("one_pc4", fq.o_pc_plus4, 64'h1004);
    chk("one_instr", 64'(fq.o_instr), 64'h00A0_0093);
    chk("one_count", 64'(fq.o_count), 64'd1);
    cyc();
    chk("one_empty_valid", 64'(fq.o_valid), 64'd0);
    chk("one_empty_count", 64'(fq.o_count), 64'd0);
`else
    // Bypass: empty queue shows the fill in the same cycle and never stores it
    set_fill(64'h4000, 32'h0000_0113, 1'b0, 2'd1, 64'd0);
    #1;
    chk("byp_valid", 64'(fq.o_valid), 64'd1);
    chk("byp_pc", fq.o_pc, 64'h4000);
    chk("byp_pc4", fq.o_pc_plus4, 64'h4004);
    chk("byp_count", 64'(fq.o_count), 64'd0);
    cyc();
    no_fill();
    #1;
    chk("byp_after_count", 64'(fq.o_count), 64'd0);
    chk("byp_after_valid", 64'(fq.o_valid), 64'd0);
`endif

    // Stalled fill to full, head holds, then drain in order
    fq.i_stall_dec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_fill(64'h2000 + 64'(4 * i), 32'h100 + 32'(i), 1'b0, 2'd0, 64'd0);
      cyc();
    end
    no_fill();
    #1;
    chk("full_count", 64'(fq.o_count), 64'd4);
    chk("full_ready", 64'(fq.o_fill_ready), 64'd0);
    chk("full_head", fq.o_pc, 64'h2000);
    cyc();
    chk("stall_hold_head", fq.o_pc, 64'h2000);
    chk("stall_hold_count", 64'(fq.o_count), 64'd4);
    fq.i_stall_dec = 1'b0;
    #1;
    chk("drain0_pc", fq.o_pc, 64'h2000);
    chk("drain0_instr", 64'(fq.o_instr), 64'h100);
    cyc();
    chk("drain1_pc", fq.o_pc, 64'h2004);
    chk("drain1_count", 64'(fq.o_count), 64'd3);
    cyc();
    chk("drain2_pc", fq.o_pc, 64'h2008);
    cyc();
    chk("drain3_pc", fq.o_pc, 64'h200C);
    chk("drain3_instr", 64'(fq.o_instr), 64'h103);
    cyc();
    chk("drained_count", 64'(fq.o_count), 64'd0);
    chk("drained_valid", 64'(fq.o_valid), 64'd0);

    // Full + dequeue with fill offered: fill rejected; then fill + dequeue keeps count
    fq.i_stall_dec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_fill(64'h5000 + 64'(4 * i), 32'h200 + 32'(i), 1'b0, 2'd0, 64'd0);
      cyc();
    end
    fq.i_stall_dec = 1'b0;
    set_fill(64'h6000, 32'h0000_0300, 1'b1, 2'd3, 64'h7777);
    #1;
    chk("fdq_ready", 64'(fq.o_fill_ready), 64'd0);
    chk("fdq_head", fq.o_pc, 64'h5000);
    cyc();
    chk("fdq_count", 64'(fq.o_count), 64'd3);
    chk("fdq_head2", fq.o_pc, 64'h5004);
    chk("fdq_ready2", 64'(fq.o_fill_ready), 64'd1);
    cyc();
    no_fill();
    #1;
    chk("both_count", 64'(fq.o_count), 64'd3);
    chk("both_head", fq.o_pc, 64'h5008);
    cyc();
    chk("wrap_head1", fq.o_pc, 64'h500C);
    cyc();
    chk("wrap_head2", fq.o_pc, 64'h6000);
    chk("wrap_taken", 64'(fq.o_branch_pred_taken), 64'd1);
    chk("wrap_way", 64'(fq.o_btb_way), 64'd3);
    chk("wrap_tgt", fq.o_pc_target_pred, 64'h7777);
    chk("wrap_count", 64'(fq.o_count), 64'd1);
    cyc();
    chk("wrap_empty", 64'(fq.o_count), 64'd0);

    // Flush with a same-cycle fill drops everything
    fq.i_stall_dec = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fill(64'h7000 + 64'(4 * i), 32'h400 + 32'(i), 1'b0, 2'd0, 64'd0);
      cyc();
    end
    chk("pre_flush_count", 64'(fq.o_count), 64'd3);
    flush = 1'b1;
    set_fill(64'h8000, 32'h0000_0500, 1'b0, 2'd0, 64'd0);
    cyc();
    flush = 1'b0;
    no_fill();
    #1;
    chk("flush_count", 64'(fq.o_count), 64'd0);
    chk("flush_valid", 64'(fq.o_valid), 64'd0);
    chk("flush_instr", 64'(fq.o_instr), 64'h13);
    cyc();
    chk("flush_fill_absent", 64'(fq.o_count), 64'd0);
    set_fill(64'h9000, 32'h0000_0600, 1'b0, 2'd0, 64'd0);
    cyc();
    no_fill();
    #1;
    chk("post_flush_count", 64'(fq.o_count), 64'd1);
    chk("post_flush_pc", fq.o_pc, 64'h9000);
    fq.i_stall_dec = 1'b0;
    cyc();

    // PC + 4 wraps at all-ones; metadata intact
    fq.i_stall_dec = 1'b1;
    set_fill(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_006F, 1'b1, 2'd2, 64'h3000);
    cyc();
    no_fill();
    #1;
    chk("wrap4_pc", fq.o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap4_pc4", fq.o_pc_plus4, 64'd0);
    chk("wrap4_taken", 64'(fq.o_branch_pred_taken), 64'd1);
    chk("wrap4_way", 64'(fq.o_btb_way), 64'd2);
    chk("wrap4_tgt", fq.o_pc_target_pred, 64'h3000);
    chk("wrap4_instr", 64'(fq.o_instr), 64'h6F);
    fq.i_stall_dec = 1'b0;
    cyc();
    chk("wrap4_drained", 64'(fq.o_count), 64'd0);

    // Asynchronous reset mid-operation empties the queue immediately
    fq.i_stall_dec = 1'b1;
    set_fill(64'hA000, 32'h0000_0700, 1'b0, 2'd0, 64'd0);
    cyc();
    set_fill(64'hA004, 32'h0000_0704, 1'b0, 2'd0, 64'd0);
    cyc();
    no_fill();
    #1;
    chk("pre_arst_count", 64'(fq.o_count), 64'd2);
    arst = 1'b1;
    #1;
    chk("arst_count", 64'(fq.o_count), 64'd0);
    chk("arst_valid", 64'(fq.o_valid), 64'd0);
    chk("arst_ready", 64'(fq.o_fill_ready), 64'd1);
    cyc();
    arst = 1'b0;
    fq.i_stall_dec = 1'b0;
    cyc();
    chk("arst_released_count", 64'(fq.o_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Show-ahead instruction queue between the instruction-cache response and the fetch/decode pipeline register.
- Buffers fetched instructions together with their branch-prediction metadata.
- Drives the decode register's instr, pc, pc_plus4, branch_pred_taken, btb_way and pc_target_pred inputs.
- Honours the decode stall and flushes on redirect.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- ADDR_WIDTH, 64: PC and target width.
- INSTR_WIDTH, 32: instruction width.

Ports:
- i_clk  in  1  clock
- i_arst  in  1  asynchronous active-high reset
- i_flush  in  1  redirect or mispredict; discards all queued entries
- i_stall_dec  in  1  decode register stalled; head is not consumed
- i_fill_valid  in  1  cache delivers one instruction this cycle
- i_fill_instr  in  INSTR_WIDTH  fetched instruction
- i_fill_pc  in  ADDR_WIDTH  PC of the fetched instruction
- i_fill_pred_taken  in  1  BTB predicted taken
- i_fill_btb_way  in  2  BTB hit way
- i_fill_pc_target_pred  in  ADDR_WIDTH  predicted target
- o_fill_ready  out  1  queue can accept a fill this cycle
- o_valid  out  1  head entry valid
- o_instr  out  INSTR_WIDTH  head instruction, or NOP when empty
- o_pc  out  ADDR_WIDTH  head PC
- o_pc_plus4  out  ADDR_WIDTH  head PC + 4
- o_branch_pred_taken  out  1  head prediction
- o_btb_way  out  2  head BTB way
- o_pc_target_pred  out  ADDR_WIDTH  head predicted target
- o_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: clock i_clk, reset i_arst, asynchronous, active-high.
  - Read/write pointers and count clear to 0, so o_valid=0, o_count=0, o_fill_ready=1.
  - Storage array is not reset.
- Enqueue when i_fill_valid & o_fill_ready. The entry is written at wr_ptr and becomes visible at the head the next cycle.
- o_fill_ready = (count != DEPTH). It is registered-state only, with no combinational dependence on i_stall_dec.
- Dequeue when o_valid & ~i_stall_dec; rd_ptr advances on the next edge.
- Head outputs are combinational from the entry at rd_ptr.
- Empty (count==0):
  - o_valid=0, o_instr=NOP (32'h0000_0013).
  - o_pc, o_pc_plus4, o_pc_target_pred, o_btb_way and o_branch_pred_taken are all 0.
- o_pc_plus4 = o_pc + 4, truncated to ADDR_WIDTH (wraps at all-ones).
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is allowed when full only if the fill is ready, which it is not while full. Full plus dequeue therefore gives count-1.
- Pointers wrap modulo DEPTH.
- Flush: on the next edge, both pointers and count go to 0.
  - Flush has priority over enqueue and dequeue in the same cycle; a same-cycle fill is dropped.
- Stall while empty: no effect.
- Reset asserted mid-operation: immediately empties the queue; any queued contents are lost.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- When defined and the queue is empty with i_fill_valid=1 and i_flush=0:
  - Head outputs show the fill data in the same cycle and o_valid=1.
  - If i_stall_dec=0, the fill is consumed directly and never written, so count stays 0.
  - If i_stall_dec=1, it is written normally.
- When not defined: an empty queue always presents a bubble, and minimum fill-to-head latency is 1 cycle.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef fetch_entry_t packing instr, pc, pred_taken, btb_way and pc_target_pred;
  - constant NOP_INSTR = 32'h0000_0013.
- The storage array is natural as a sub-module, fetch_queue_mem: DEPTH x fetch_entry_t, one write port, one async read port, no reset.

Test Plan:
- Reset, then idle → o_valid=0, o_instr=0x00000013, o_count=0, o_fill_ready=1.
- Fill pc=0x1000 instr=0x00A00093 with i_stall_dec=0 → next cycle o_valid=1, o_pc=0x1000, o_pc_plus4=0x1004; following cycle empty.
- Hold i_stall_dec=1, fill 4 entries at pc 0x2000..0x200C → o_count=4, o_fill_ready=0, head stays 0x2000. Release the stall → heads 0x2000, 0x2004, 0x2008, 0x200C in order.
- Full queue with simultaneous dequeue, and fill offered → fill rejected, count 4→3. Next cycle fill plus dequeue → count stays 3 and the pointers wrap correctly.
- Queue holding 3 entries, i_flush=1 together with i_fill_valid=1 → next cycle o_count=0, o_valid=0, and the fill entry is absent.
- pc=0xFFFF_FFFF_FFFF_FFFC with pred_taken=1, btb_way=2, target=0x3000 → o_pc_plus4=0, metadata passed intact.
- With FETCH_QUEUE_BYPASS_EN: empty queue, fill pc=0x4000, no stall → o_valid=1 and o_pc=0x4000 in the same cycle, o_count stays 0.
